// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a framed byte stream into 16-bit words, writes instruction memory,
// verifies an XOR checksum and releases the RISC core from reset on success.
module imem_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERR
    } state_t;

    state_t            state, nxt;
    logic [7:0]        hi_byte;
    logic [15:0]       n_words;
    logic [ADDR_W:0]   idx;
    logic [7:0]        xsum;
    logic [TMR_W-1:0]  timer;

    logic        accept;
    logic        timing;
    logic        timed_out;
    logic [15:0] len;
    logic        last_word;

    assign accept    = in_valid & in_ready;
    assign timing    = (state == LEN_LO) || (state == DATA_HI) ||
                       (state == DATA_LO) || (state == CSUM);
    // An accepted byte in the expiry cycle takes precedence over the timeout.
    assign timed_out = timing && !accept && (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign len       = {hi_byte, in_data};
    assign last_word = (16'(idx) + 16'd1) == n_words;

    always_comb begin
        nxt = state;
        unique case (state)
            LEN_HI:  if (accept) nxt = LEN_LO;
            LEN_LO:
                if (accept) begin
                    if (len == 16'd0)                 nxt = CSUM;
                    else if (len > 16'(MAX_WORDS))    nxt = ERR;
                    else                              nxt = DATA_HI;
                end else if (timed_out) nxt = ERR;
            DATA_HI:
                if (accept)         nxt = DATA_LO;
                else if (timed_out) nxt = ERR;
            DATA_LO:
                if (accept)         nxt = last_word ? CSUM : DATA_HI;
                else if (timed_out) nxt = ERR;
            CSUM:
                if (accept)         nxt = (xsum == in_data) ? RUN : ERR;
                else if (timed_out) nxt = ERR;
            RUN, ERR: if (reload) nxt = LEN_HI;
            default: nxt = LEN_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LEN_HI;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            hi_byte    <= '0;
            n_words    <= '0;
            idx        <= '0;
            xsum       <= '0;
            timer      <= '0;
        end else begin
            state      <= nxt;
            in_ready   <= (nxt != RUN) && (nxt != ERR);
            done       <= (nxt == RUN);
            core_rst_n <= (nxt == RUN);
            err        <= (nxt == ERR);
            imem_we    <= 1'b0;

            if (accept || !timing) timer <= '0;
            else                   timer <= timer + 1'b1;

            if (accept) begin
                unique case (state)
                    LEN_HI: begin
                        hi_byte <= in_data;
                        xsum    <= xsum ^ in_data;
                    end
                    LEN_LO: begin
                        n_words <= len;
                        xsum    <= xsum ^ in_data;
                    end
                    DATA_HI: begin
                        hi_byte <= in_data;
                        xsum    <= xsum ^ in_data;
                    end
                    DATA_LO: begin
                        imem_wdata <= {hi_byte, in_data};
                        imem_addr  <= idx[ADDR_W-1:0];
                        imem_we    <= 1'b1;
                        idx        <= idx + 1'b1;
                        xsum       <= xsum ^ in_data;
                    end
                    default: ;
                endcase
            end

            if (reload && ((state == RUN) || (state == ERR))) begin
                idx  <= '0;
                xsum <= '0;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued as frames are sent
// and checked by a write monitor; state outputs are checked at each directed step.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_q[$];

    imem_boot_loader #(
        .ADDR_W(8),
        .MAX_WORDS(256),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .reload(reload),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr=%h data=%h expected no write",
                       imem_addr, imem_wdata);
            end
            if (exp_q.size() != 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                vectors++;
                assert ({imem_addr, imem_wdata} === e) else begin
                    miscompares++;
                    $error("FAIL write_content: observed %h expected %h",
                           {imem_addr, imem_wdata}, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bytes are held valid back-to-back; the caller drops in_valid when a frame ends.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        in_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1'b1);
        chk({tag, "_we"},         imem_we,    1'b0);
        chk({tag, "_addr"},       imem_addr,  8'h00);
        chk({tag, "_wdata"},      imem_wdata, 16'h0000);
        chk({tag, "_core_rst_n"}, core_rst_n, 1'b0);
        chk({tag, "_done"},       done,       1'b0);
        chk({tag, "_err"},        err,        1'b0);
    endtask

    // Sends the two-word frame 1234/ABCD with a caller-chosen checksum byte.
    task automatic two_word_frame(input logic [7:0] csum);
        send(8'h00);
        send(8'h02);
        send(8'h12);
        exp_q.push_back({8'h00, 16'h1234});
        send(8'h34);
        chk("w0_we_latency", imem_we, 1'b1);
        chk("w0_addr", imem_addr, 8'h00);
        send(8'hAB);
        chk("w0_we_single", imem_we, 1'b0);
        chk("w0_wdata_hold", imem_wdata, 16'h1234);
        exp_q.push_back({8'h01, 16'hABCD});
        send(8'hCD);
        chk("w1_we_latency", imem_we, 1'b1);
        chk("w1_done_early", done, 1'b0);
        send(csum);
        in_valid = 1'b0;
        chk("csum_we_off", imem_we, 1'b0);
    endtask

    initial begin
        logic [7:0] good_csum;
        good_csum = 8'h00 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD;

        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("post_reset");

        // Valid two-word frame -> RUN
        two_word_frame(good_csum);
        chk("a_done", done, 1'b1);
        chk("a_core_rst_n", core_rst_n, 1'b1);
        chk("a_in_ready", in_ready, 1'b0);
        chk("a_err", err, 1'b0);
        chk("a_addr_hold", imem_addr, 8'h01);
        chk("a_wdata_hold", imem_wdata, 16'hABCD);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("run_ignores_valid", done, 1'b1);
        pulse_reload();
        chk("reload_run_done", done, 1'b0);
        chk("reload_run_core", core_rst_n, 1'b0);
        chk("reload_run_ready", in_ready, 1'b1);

        // Bad checksum -> ERR after both writes
        two_word_frame(good_csum ^ 8'h01);
        chk("b_err", err, 1'b1);
        chk("b_core_rst_n", core_rst_n, 1'b0);
        chk("b_in_ready", in_ready, 1'b0);
        chk("b_done", done, 1'b0);
        pulse_reload();
        chk("reload_err_err", err, 1'b0);
        chk("reload_err_ready", in_ready, 1'b1);

        // Empty program
        send(8'h00);
        send(8'h00);
        send(8'h00);
        in_valid = 1'b0;
        chk("empty_done", done, 1'b1);
        chk("empty_err", err, 1'b0);
        pulse_reload();

        // Oversized length (257)
        send(8'h01);
        send(8'h01);
        in_valid = 1'b0;
        chk("oversize_err", err, 1'b1);
        chk("oversize_ready", in_ready, 1'b0);
        pulse_reload();

        // Length exactly MAX_WORDS is accepted into the data phase
        send(8'h01);
        send(8'h00);
        in_valid = 1'b0;
        chk("max_len_not_err", err, 1'b0);
        chk("max_len_ready", in_ready, 1'b1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Timeout after exactly 16 idle cycles
        send(8'h00);
        send(8'h01);
        send(8'h12);
        idle(15);
        chk("timeout_minus1", err, 1'b0);
        idle(1);
        chk("timeout_err", err, 1'b1);
        chk("timeout_core", core_rst_n, 1'b0);
        pulse_reload();

        // Asynchronous reset between DATA_HI and DATA_LO of word 1
        send(8'h00);
        send(8'h02);
        send(8'h12);
        exp_q.push_back({8'h00, 16'h1234});
        send(8'h34);
        send(8'hAB);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe_reset");
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        two_word_frame(good_csum);
        chk("rerun_done", done, 1'b1);
        chk("rerun_core", core_rst_n, 1'b1);

        idle(2);
        chk("writes_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
